// File: rtl/debug_ocimem_if.sv
// Avalon-MM slave bus into the debug on-chip memory.
// master drives requests; slave returns data and stall.
interface debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;

  modport master (
    output av_address, av_read, av_write,
    output av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write,
    input  av_writedata, av_byteenable,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/debug_ocimem_ctrl.sv
// Debug on-chip memory shared by the JTAG monitor and an Avalon slave.
// JTAG pulses arriving while busy wait in a one-entry pending slot.
module debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  debug_ocimem_if.slave     av,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {
    IDLE, J_RD, J_RD_D, J_WR, A_RD, A_RD_D, A_WR
  } state_t;

  typedef enum logic [1:0] {
    ACT_A, ACT_NA, ACT_B
  } act_t;

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;
  logic [31:0] jwr_q;

  state_t      state;
  logic        pend_vld;
  act_t        pend_typ;
  logic [31:0] pend_j;

  logic        new_vld;
  logic        new_multi;
  act_t        new_typ;
  logic        ex_vld;
  act_t        ex_typ;
  logic [31:0] ex_j;

  logic a_p, na_p, b_p;
  logic unused_jdo;

  assign a_p  = take_action_ocimem_a;
  assign na_p = take_no_action_ocimem_a;
  assign b_p  = take_action_ocimem_b;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // ex_j holds jdo[34:3], so jdo[k] sits at ex_j[k-3]
  always_comb begin
    new_vld   = a_p | na_p | b_p;
    new_multi = (b_p & a_p) | (b_p & na_p) | (a_p & na_p);
    new_typ   = ACT_NA;
    if (b_p)      new_typ = ACT_B;
    else if (a_p) new_typ = ACT_A;
    ex_vld = (state == IDLE) && (new_vld || pend_vld);
    ex_typ = new_vld ? new_typ : pend_typ;
    ex_j   = new_vld ? jdo[34:3] : pend_j;
  end

  always_ff @(posedge clk) begin
    ram_q <= mem[MonAReg];
    if (state == J_WR)
      mem[MonAReg] <= jwr_q;
    if (state == A_WR)
      for (int i = 0; i < 4; i++)
        if (av.av_byteenable[i])
          mem[av.av_address][8*i +: 8] <= av.av_writedata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      pend_vld          <= 1'b0;
      pend_typ          <= ACT_A;
      pend_j            <= '0;
      jwr_q             <= '0;
      MonDReg           <= '0;
      MonAReg           <= '0;
      jtag_overrun      <= 1'b0;
      av.av_readdata    <= '0;
      av.av_waitrequest <= 1'b1;
    end else begin
      av.av_waitrequest <= 1'b1;
      if (new_multi)
        jtag_overrun <= 1'b1;
      if (new_vld && state != IDLE) begin
        if (pend_vld) begin
          jtag_overrun <= 1'b1;
        end else begin
          pend_vld <= 1'b1;
          pend_typ <= new_typ;
          pend_j   <= jdo[34:3];
        end
      end
      unique case (state)
        IDLE: begin
          if (ex_vld) begin
            if (!new_vld)
              pend_vld <= 1'b0;
            unique case (ex_typ)
              ACT_A: begin
                MonAReg <= ex_j[13+ADDR_W:14];
                if (ex_j[31])
                  state <= J_RD;
              end
              ACT_NA: begin
                MonAReg <= MonAReg + ADDR_W'(1);
                state   <= J_RD;
              end
              default: begin
                jwr_q <= ex_j;
                state <= J_WR;
              end
            endcase
          end else if (av.av_write) begin
            state             <= A_WR;
            av.av_waitrequest <= 1'b0;
          end else if (av.av_read) begin
            state <= A_RD;
          end
        end
        J_RD:   state <= J_RD_D;
        J_RD_D: begin
          MonDReg <= ram_q;
          state   <= IDLE;
        end
        J_WR: begin
          MonAReg <= MonAReg + ADDR_W'(1);
          state   <= IDLE;
        end
        A_RD: begin
          av.av_readdata    <= mem[av.av_address];
          av.av_waitrequest <= 1'b0;
          state             <= A_RD_D;
        end
        A_RD_D: state <= IDLE;
        A_WR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Directed bench for debug_ocimem_ctrl: Avalon vector table
// plus hand-written JTAG, pending, overrun and reset sequences.
module tb_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        act_a, act_na, act_b;
  logic [31:0] mon_d;
  logic [7:0]  mon_a;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  debug_ocimem_if #(.ADDR_W(8)) av ();

  debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_no_action_ocimem_a (act_na),
    .take_action_ocimem_b    (act_b),
    .av                      (av),
    .MonDReg                 (mon_d),
    .MonAReg                 (mon_a),
    .jtag_overrun            (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } av_vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jaddr(input logic [7:0] a,
                                        input logic rd);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // mask: bit0 action_a, bit1 no_action_a, bit2 action_b
  task automatic pulse(input logic [2:0] m, input logic [37:0] j);
    jdo = j;
    act_a = m[0];
    act_na = m[1];
    act_b = m[2];
    cyc();
    act_a = 1'b0;
    act_na = 1'b0;
    act_b = 1'b0;
  endtask

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit rd_too);
    int n;
    n = 0;
    av.av_address = a;
    av.av_writedata = d;
    av.av_byteenable = be;
    av.av_write = 1'b1;
    av.av_read = rd_too;
    do begin
      cyc();
      n++;
    end while (av.av_waitrequest && n < 10);
    chk("wr_latency", n, 1);
    cyc();
    av.av_write = 1'b0;
    av.av_read = 1'b0;
    chk("wr_wait_high", {31'b0, av.av_waitrequest}, 1);
  endtask

  task automatic av_rd(input logic [7:0] a, input logic [31:0] exp);
    int n;
    n = 0;
    av.av_address = a;
    av.av_read = 1'b1;
    do begin
      cyc();
      n++;
    end while (av.av_waitrequest && n < 10);
    chk("rd_latency", n, 2);
    chk("rd_data", av.av_readdata, exp);
    cyc();
    av.av_read = 1'b0;
    chk("rd_wait_high", {31'b0, av.av_waitrequest}, 1);
  endtask

  av_vec_t vecs [12];

  initial begin
    vecs[0]  = '{1, 8'd5,   32'h12345678, 4'hF, 32'h0};
    vecs[1]  = '{1, 8'd10,  32'h00000000, 4'hF, 32'h0};
    vecs[2]  = '{1, 8'd10,  32'hAABBCCDD, 4'h5, 32'h0};
    vecs[3]  = '{0, 8'd10,  32'h0,        4'h0, 32'h00BB00DD};
    vecs[4]  = '{0, 8'd5,   32'h0,        4'h0, 32'h12345678};
    vecs[5]  = '{1, 8'd1,   32'h11112222, 4'hF, 32'h0};
    vecs[6]  = '{1, 8'd0,   32'h0BADBEEF, 4'hF, 32'h0};
    vecs[7]  = '{1, 8'd7,   32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[8]  = '{1, 8'd7,   32'h01020304, 4'hA, 32'h0};
    vecs[9]  = '{0, 8'd7,   32'h0,        4'h0, 32'h01FF03FF};
    vecs[10] = '{0, 8'd1,   32'h0,        4'h0, 32'h11112222};
    vecs[11] = '{0, 8'd0,   32'h0,        4'h0, 32'h0BADBEEF};

    reset_n = 1'b0;
    jdo = '0;
    act_a = 1'b0;
    act_na = 1'b0;
    act_b = 1'b0;
    av.av_address = '0;
    av.av_read = 1'b0;
    av.av_write = 1'b0;
    av.av_writedata = '0;
    av.av_byteenable = '0;
    cyc();
    cyc();
    chk("rst_mond", mon_d, 0);
    chk("rst_mona", {24'b0, mon_a}, 0);
    chk("rst_rdata", av.av_readdata, 0);
    chk("rst_wait", {31'b0, av.av_waitrequest}, 1);
    chk("rst_ovr", {31'b0, overrun}, 0);
    reset_n = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      if (vecs[i].wr)
        av_wr(vecs[i].addr, vecs[i].data, vecs[i].be, 1'b0);
      else
        av_rd(vecs[i].addr, vecs[i].exp);
    end

    // read plus write together acts as a write
    av_wr(8'd3, 32'h33334444, 4'hF, 1'b1);
    av_rd(8'd3, 32'h33334444);

    // jtag read: MonDReg lands on the third edge after the pulse
    pulse(3'b001, jaddr(8'd5, 1'b1));
    chk("ja_mona", {24'b0, mon_a}, 5);
    cyc();
    chk("ja_mond_early", mon_d, 0);
    cyc();
    chk("ja_mond", mon_d, 32'h12345678);

    // address load only, write with wrap, then increment-read
    pulse(3'b001, jaddr(8'd255, 1'b0));
    chk("ld_mona", {24'b0, mon_a}, 255);
    chk("ld_mond_hold", mon_d, 32'h12345678);
    pulse(3'b100, jdata(32'hCAFEF00D));
    cyc();
    chk("jb_wrap", {24'b0, mon_a}, 0);
    pulse(3'b010, '0);
    chk("na_mona", {24'b0, mon_a}, 1);
    cyc();
    cyc();
    chk("na_mond", mon_d, 32'h11112222);
    av_rd(8'd255, 32'hCAFEF00D);

    // jtag pulses during an avalon read: first pends, second drops
    av.av_address = 8'd5;
    av.av_read = 1'b1;
    cyc();
    pulse(3'b100, jdata(32'h5A5A0001));
    chk("pend_rd_wait", {31'b0, av.av_waitrequest}, 0);
    chk("pend_rd_data", av.av_readdata, 32'h12345678);
    pulse(3'b010, '0);
    av.av_read = 1'b0;
    chk("pend_ovr", {31'b0, overrun}, 1);
    chk("pend_wait_hi", {31'b0, av.av_waitrequest}, 1);
    cyc();
    cyc();
    chk("pend_mona", {24'b0, mon_a}, 2);
    chk("pend_mond", mon_d, 32'h11112222);
    av_rd(8'd1, 32'h5A5A0001);

    // increment-read wraps 255 -> 0
    pulse(3'b001, jaddr(8'd255, 1'b0));
    pulse(3'b010, '0);
    chk("wrap_mona", {24'b0, mon_a}, 0);
    cyc();
    cyc();
    chk("wrap_mond", mon_d, 32'h0BADBEEF);

    // reset in J_RD forces outputs immediately
    pulse(3'b001, jaddr(8'd5, 1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_mond", mon_d, 0);
    chk("mid_mona", {24'b0, mon_a}, 0);
    chk("mid_rdata", av.av_readdata, 0);
    chk("mid_wait", {31'b0, av.av_waitrequest}, 1);
    chk("mid_ovr", {31'b0, overrun}, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_mond", mon_d, 0);
    av_rd(8'd5, 32'h12345678);
    av_rd(8'd1, 32'h5A5A0001);

    // simultaneous pulses: action_a wins, overrun set
    pulse(3'b011, jaddr(8'd9, 1'b0));
    chk("multi_mona", {24'b0, mon_a}, 9);
    chk("multi_ovr", {31'b0, overrun}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
